// File: rtl/gt_cache_pkg.sv
// Shared L1 / victim cache definitions: line and tag geometry,
// line_t / tag_t types and the address-to-line-tag helper.
package gt_cache_pkg;

  localparam int LINE_W   = 256;
  localparam int TAG_W    = 27;
  localparam int OFFSET_W = 5;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [TAG_W-1:0]  tag_t;

  function automatic tag_t line_tag(input logic [31:0] addr);
    return addr[31:OFFSET_W];
  endfunction

endpackage

// File: rtl/gt_victim_cam.sv
// Combinational tag CAM: compares one probe tag against every valid entry.
// Ports: valid/tags (entry state), probe; match_oh, match_idx (lowest), any_match.
module gt_victim_cam #(
  parameter int DEPTH = 8,
  parameter int TAG_W = gt_cache_pkg::TAG_W
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]            probe,
  output logic [DEPTH-1:0]            match_oh,
  output logic [$clog2(DEPTH)-1:0]    match_idx,
  output logic                        any_match
);

  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    match_oh  = '0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_oh[i] = valid[i] && (tags[i] == probe);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_oh[i]) match_idx = IDX_W'(i);
    end
    any_match = |match_oh;
  end

endmodule

// File: rtl/gt_victim_cache.sv
// Exclusive, fully associative victim cache behind the direct-mapped L1.
// Ports: CLK, RST (async, active-high), flush; lookup_valid/lookup_tag;
// evict_valid/evict_tag/evict_data; registered resp_valid/resp_hit/resp_data;
// occupancy. Macro GT_VICTIM_STATS_EN adds saturating hit_count/miss_count.
module gt_victim_cache #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = gt_cache_pkg::TAG_W,
  parameter int LINE_W = gt_cache_pkg::LINE_W
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       lookup_valid,
  input  logic [TAG_W-1:0]           lookup_tag,
  input  logic                       evict_valid,
  input  logic [TAG_W-1:0]           evict_tag,
  input  logic [LINE_W-1:0]          evict_data,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic [LINE_W-1:0]          resp_data,
`ifdef GT_VICTIM_STATS_EN
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count,
`endif
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [DEPTH-1:0][LINE_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]              rr_q, rr_d;
  logic                          resp_valid_q, resp_valid_d;
  logic                          resp_hit_q, resp_hit_d;
  logic [LINE_W-1:0]             resp_data_q, resp_data_d;
  logic [OCC_W-1:0]              occ_q, occ_d;

  logic [DEPTH-1:0] lk_oh, ev_oh;
  logic [IDX_W-1:0] lk_idx, ev_idx, free_idx, wr_idx;
  logic             lk_any, ev_any, free_any, wr_en, fwd, lk_hit;

  gt_victim_cam #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_cam_lk (
    .valid(valid_q), .tags(tag_q), .probe(lookup_tag),
    .match_oh(lk_oh), .match_idx(lk_idx), .any_match(lk_any)
  );

  gt_victim_cam #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_cam_ev (
    .valid(valid_q), .tags(tag_q), .probe(evict_tag),
    .match_oh(ev_oh), .match_idx(ev_idx), .any_match(ev_any)
  );

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    free_any = ~&valid_q;
    fwd      = lookup_valid && evict_valid && (lookup_tag == evict_tag);
    lk_hit   = lookup_valid && lk_any;
  end

  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    rr_d         = rr_q;
    resp_valid_d = lookup_valid;
    resp_hit_d   = 1'b0;
    resp_data_d  = '0;
    wr_en        = 1'b0;
    wr_idx       = '0;
    if (flush) begin
      valid_d = '0;
      rr_d    = '0;
    end else if (fwd) begin
      // Line bounces straight back to L1; drop every stored copy.
      resp_hit_d  = 1'b1;
      resp_data_d = evict_data;
      valid_d     = valid_q & ~lk_oh;
    end else begin
      if (lk_hit) begin
        resp_hit_d      = 1'b1;
        resp_data_d     = data_q[lk_idx];
        valid_d[lk_idx] = 1'b0;
      end
      if (evict_valid) begin
        wr_en = 1'b1;
        if (lk_hit)        wr_idx = lk_idx;
        else if (ev_any)   wr_idx = ev_idx;
        else if (free_any) wr_idx = free_idx;
        else begin
          wr_idx = rr_q;
          rr_d   = rr_q + 1'b1;
        end
      end
    end
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = evict_tag;
      data_d[wr_idx]  = evict_data;
    end
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q      <= '0;
      rr_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      occ_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      rr_q         <= rr_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_data_q  <= resp_data_d;
      occ_q        <= occ_d;
    end
  end

  // Payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_data  = resp_data_q;
  assign occupancy  = occ_q;

`ifdef GT_VICTIM_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (resp_valid_d && resp_hit_d && (hit_cnt_q != 32'hFFFF_FFFF))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (resp_valid_d && !resp_hit_d && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
